// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared widths, size encodings and FSM states for           |
// |           mem_access_unit.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // The reserved size code is reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lsb[0];
      SZ_WORD: misaligned = |lsb;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_merge : little-endian byte/half insert for stores and           |
// |              extract + zero/sign extend for loads.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lane_merge
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    size,
  input  logic [1:0]    lsb,
  input  logic          sign_ext,
  output logic [DW-1:0] merged,
  output logic [DW-1:0] extracted
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word[{lsb, 3'b000} +: 8];
  assign w_half = word[{lsb[1], 4'b0000} +: 16];

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lsb, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merged[{lsb[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: extracted = {{(DW-8){sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: extracted = {{(DW-16){sign_ext & w_half[15]}}, w_half};
      default: extracted = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_unit : MEM-stage to word-wide data memory controller with |
// |                   sub-word read-modify-write stores.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = mem_pkg::AW,
  parameter int DW = mem_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  output logic          memwrite,
  output logic          memread,
  input  logic [DW-1:0] readdata
);

  state_t        r_state;
  state_t        w_next;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_wdata;
  logic          w_mis;
  logic          w_rd;
  logic          w_wr;
  logic          w_done;
  logic [DW-1:0] w_merged;
  logic [DW-1:0] w_extracted;

  assign w_mis = misaligned(req_size, req_addr[1:0]);

  lane_merge #(.DW(DW)) u_lane_merge (
    .word      (readdata),
    .wdata     (req_wdata),
    .size      (req_size),
    .lsb       (req_addr[1:0]),
    .sign_ext  (req_signed),
    .merged    (w_merged),
    .extracted (w_extracted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_mis)                    w_next = S_DONE;
          else if (!req_write)          w_next = S_RD;
          else if (req_size == SZ_WORD) w_next = S_WR;
          else                          w_next = S_RMW_RD;
        end
      end
      S_RD:     w_next = S_DONE;
      S_RMW_RD: w_next = S_WR;
      S_WR:     w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes decode from state alone so reset drops them without a clock edge.
  always_comb begin
    w_rd   = (r_state == S_RD) || (r_state == S_RMW_RD);
    w_wr   = (r_state == S_WR);
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_err   <= w_mis;
            r_rdata <= '0;
            r_wdata <= req_wdata;
          end
        end
        S_RD:     r_rdata <= w_extracted;
        S_RMW_RD: r_wdata <= w_merged;
        default:  ;
      endcase
    end
  end

  assign memread    = w_rd;
  assign memwrite   = w_wr;
  assign resp_valid = w_done;
  assign resp_err   = w_done & r_err;
  assign resp_rdata = r_rdata;
  assign writedata  = r_wdata;
  assign address    = {req_addr[AW-1:2], 2'b00};
  assign stall      = req_valid & ~resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_unit : scoreboard bench with a word memory model and a |
// |                      byte-level reference of the request semantics.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_err, memwrite, memread;
  logic [31:0] resp_rdata, address, writedata, readdata;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
    .writedata(writedata), .memwrite(memwrite), .memread(memread),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [0:63];
  logic [31:0] ref_mem [0:63];
  always @(posedge clk) if (memwrite) dmem[address[7:2]] <= writedata;
  assign readdata = memread ? dmem[address[7:2]] : 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          rd_off;
    int          nwr;
    int          wr_off;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what each request must do, stated in bytes and shifts.
  task automatic predict(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int idx, off, nbytes;
    logic [31:0] word, mask, v;
    idx = int'(a[7:2]);
    off = int'(a % 4);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = '{rdata: 32'h0, err: 1'b0, lat: 0, nrd: 0, rd_off: -1, nwr: 0, wr_off: -1, wd: 32'h0};
    if (sz == 2'd3 || (off % nbytes) != 0) begin
      e.err = 1'b1; e.lat = 1;
      return;
    end
    word = ref_mem[idx];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
    if (!w) begin
      v = (word >> (8 * off)) & mask;
      if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      e.rdata = v; e.lat = 2; e.nrd = 1; e.rd_off = 1;
    end else if (nbytes == 4) begin
      ref_mem[idx] = wd;
      e.wd = wd; e.lat = 2; e.nwr = 1; e.wr_off = 1;
    end else begin
      v = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[idx] = v;
      e.wd = v; e.lat = 3; e.nrd = 1; e.rd_off = 1; e.nwr = 1; e.wr_off = 2;
    end
  endtask

  // Monitor: tracks each transaction from its first requesting cycle.
  logic        busy = 1'b0;
  int          start, nrd, nwr, rd_off, wr_off;
  logic [31:0] seen_wd;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy = 1'b0;
    end else begin
      chk("stall", 32'(stall), 32'(req_valid & ~resp_valid));
      chk("rd_wr_exclusive", 32'(memread & memwrite), 32'h0);
      if (req_valid && !busy) begin
        busy = 1'b1; start = cyc; nrd = 0; nwr = 0; rd_off = -1; wr_off = -1; seen_wd = 32'h0;
      end
      if (memread) begin
        if (nrd == 0) rd_off = cyc - start;
        nrd++;
      end
      if (memwrite) begin
        if (nwr == 0) begin wr_off = cyc - start; seen_wd = writedata; end
        nwr++;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", 32'(cyc - start), 32'(e.lat));
          chk("memread_cycles", 32'(nrd), 32'(e.nrd));
          chk("memread_offset", 32'(rd_off), 32'(e.rd_off));
          chk("memwrite_cycles", 32'(nwr), 32'(e.nwr));
          chk("memwrite_offset", 32'(wr_off), 32'(e.wr_off));
          chk("writedata", seen_wd, e.wd);
        end
        busy = 1'b0;
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit got = 1'b0;
    predict(w, sz, sg, a, wd, e);
    q.push_back(e);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("resp_timeout", 32'h0, 32'h1);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dmem[i] <= v;
      ref_mem[i] = v;
    end
    dmem[6] <= 32'h8000A0FF;
    ref_mem[6] = 32'h8000A0FF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_memread", 32'(memread), 32'h0);
    chk("reset_memwrite", 32'(memwrite), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_err", 32'(resp_err), 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_writedata", writedata, 32'h0);

    issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h00000F14);
    idle(1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h18, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h19, 32'h0);
    issue(1'b0, SZ_HALF, 1'b1, 32'h1A, 32'h0);
    idle(2);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h1B, 32'h0000005A);
    issue(1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h16, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h15, 32'h0000BEEF);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678);
    idle(1);

    // Reset while the byte store sits in its read half.
    req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h18; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk); #2;
    chk("rmw_read_active", 32'(memread), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_memread", 32'(memread), 32'h0);
    chk("async_rst_memwrite", 32'(memwrite), 32'h0);
    chk("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mem_untouched", dmem[6], ref_mem[6]);
    issue(1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0);

    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(3);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    for (int i = 0; i < 64; i++) chk("final_memory", dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
